// File: rtl/maxpool_stream13.sv
// Streaming global max-pool: reduces each channel's InputH*InputW signed pixels
// to one maximum and holds it until downstream accepts it.
module maxpool_stream13 #(
  parameter int DATA_WIDTH = 16,
  parameter int InputH     = 13,
  parameter int InputW     = 13,
  parameter int Depth      = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [DATA_WIDTH-1:0]                     in_data,
  input  logic                                      in_valid,
  input  logic                                      in_last,
  output logic                                      in_ready,
  output logic [DATA_WIDTH-1:0]                     out_data,
  output logic [((Depth > 1) ? $clog2(Depth) : 1)-1:0] out_ch,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      frame_done,
  output logic                                      err,
  output logic [0:0]                                dbg_state_o
);

  localparam int NPIX  = InputH * InputW;
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CH_W  = (Depth > 1) ? $clog2(Depth) : 1;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is high only in ACCUM, out_valid only in HOLD, so the two never overlap.
  logic [0:0]            state_q, state_d;
  logic [PIX_W-1:0]      pix_cnt_q, pix_cnt_d;
  logic [CH_W-1:0]       ch_cnt_q, ch_cnt_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]       out_ch_q, out_ch_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_q, err_d;

  logic in_xfer;
  logic out_xfer;
  logic last_pix;
  logic last_ch;

  assign in_ready    = (state_q == ST_ACCUM);
  assign out_valid   = (state_q == ST_HOLD);
  assign out_data    = out_data_q;
  assign out_ch      = out_ch_q;
  assign frame_done  = frame_done_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign last_pix = (pix_cnt_q == PIX_W'(NPIX - 1));
  assign last_ch  = (ch_cnt_q == CH_W'(Depth - 1));

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    ch_cnt_d     = ch_cnt_q;
    max_d        = max_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    err_d        = err_q;
    frame_done_d = 1'b0;

    if (in_xfer) begin
      // Pixel 0 seeds the max so the reset value of 0 never competes.
      if ((pix_cnt_q == '0) || ($signed(in_data) > $signed(max_q))) begin
        max_d = in_data;
      end
      // in_last is only checked against the count; it never ends a channel early.
      if (in_last != last_pix) begin
        err_d = 1'b1;
      end
      if (last_pix) begin
        pix_cnt_d  = '0;
        out_data_d = max_d;
        out_ch_d   = ch_cnt_q;
        state_d    = ST_HOLD;
      end else begin
        pix_cnt_d = pix_cnt_q + PIX_W'(1);
      end
    end

    if (out_xfer) begin
      state_d      = ST_ACCUM;
      ch_cnt_d     = last_ch ? '0 : ch_cnt_q + CH_W'(1);
      frame_done_d = last_ch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ACCUM;
      pix_cnt_q    <= '0;
      ch_cnt_q     <= '0;
      max_q        <= '0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      ch_cnt_q     <= ch_cnt_d;
      max_q        <= max_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: doc/maxpool_stream13.md
MAXPOOL_STREAM13 -- requirements
Module: maxpool_stream13

Interface
REQ-001 Parameter DATA_WIDTH, default 16: pixel width; two's-complement signed fixed-point.
REQ-002 Parameter InputH, default 13: feature-map rows per channel.
REQ-003 Parameter InputW, default 13: feature-map columns per channel.
REQ-004 Parameter Depth, default 1: channels per frame.
REQ-005 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-006 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-007 Port in_data  input  DATA_WIDTH: pixel; channel-major, row-major within a channel.
REQ-008 Port in_valid  input  1: in_data is valid.
REQ-009 Port in_last  input  1: marks the sender's last pixel of the current channel.
REQ-010 Port in_ready  output  1: block accepts a pixel this cycle.
REQ-011 Port out_data  output  DATA_WIDTH: maximum over one channel's InputH*InputW pixels.
REQ-012 Port out_ch  output  clog2(Depth) (min 1): channel index of out_data.
REQ-013 Port out_valid  output  1: out_data/out_ch valid.
REQ-014 Port out_ready  input  1: downstream accepts the result.
REQ-015 Port frame_done  output  1: one-cycle pulse when the last channel's result is accepted.
REQ-016 Port err  output  1: sticky framing error flag.

Function
REQ-017 Input transfer = in_valid & in_ready on a rising edge; output transfer = out_valid & out_ready.
REQ-018 The FSM SHALL have states ACCUM and HOLD; ACCUM after reset.
REQ-019 in_ready SHALL be 1 in ACCUM and 0 in HOLD; out_valid SHALL be 1 in HOLD and 0 in ACCUM.
REQ-020 Pixel counter pix_cnt SHALL run 0..InputH*InputW-1; +1 per input transfer.
REQ-021 On a transfer with pix_cnt=0, the running max SHALL be loaded with in_data unconditionally (no compare).
REQ-022 On a transfer with pix_cnt>0, running max SHALL update to in_data only if in_data > max (signed compare); equal values keep the max.
REQ-023 On a transfer with pix_cnt=InputH*InputW-1: out_data SHALL take the final max, including that pixel; out_ch SHALL take ch_cnt; pix_cnt SHALL go to 0; the FSM SHALL go to HOLD.
REQ-024 Latency: out_valid SHALL rise on the cycle after the last pixel's transfer edge.
REQ-025 In HOLD, out_data and out_ch SHALL stay stable until the output transfer. At that edge the FSM SHALL return to ACCUM. ch_cnt SHALL advance, wrapping Depth-1 to 0.
REQ-026 frame_done SHALL be 1 for exactly the cycle after the output transfer with ch_cnt=Depth-1; otherwise 0.
REQ-027 Each channel SHALL have a one-cycle input bubble, the HOLD cycle with out_ready=1.
REQ-028 If in_last=1 on a transfer with pix_cnt≠InputH*InputW-1, err SHALL set. The same applies if in_last=0 on a transfer with pix_cnt=InputH*InputW-1. Counting SHALL continue unchanged; in_last SHALL NOT terminate a channel.
REQ-029 err SHALL clear only on reset.
REQ-030 in_data and in_last SHALL be ignored when no input transfer occurs, including in HOLD.

Reset
REQ-031 rst_n=0 SHALL immediately force these values: FSM=ACCUM, pix_cnt=0, ch_cnt=0, running max=0, out_data=0, out_ch=0, out_valid=0, frame_done=0, err=0, in_ready=1.
REQ-032 Reset mid-channel or in HOLD SHALL discard the partial max and any pending result; the first transfer after release is pixel 0 of channel 0.

Verification
REQ-033 Depth=1: stream 169 pixels, value -100 except pixel 84 = 7, in_last on pixel 168, out_ready=1. Required: out_data=7, out_ch=0, out_valid high one cycle, frame_done pulse, err=0.
REQ-034 All 169 pixels negative, max -3 at pixel 0. Required: out_data=-3 (0xFFFD); the reset max of 0 does not leak in.
REQ-035 Depth=3, maxima 5/0x7FFF/0x8000, out_ready=0 for 10 cycles after each result. Required: in_ready=0 and out_data stable through the stall; outputs in order ch0=5, ch1=0x7FFF, ch2=0x8000; frame_done only after ch2.
REQ-036 in_last asserted on pixel 100. Required: err=1 and stays 1; the result still arrives after pixel 168.
REQ-037 rst_n pulsed low after 50 pixels, then 169 pixels with max 9. Required: out_data=9, out_ch=0; nothing from the aborted channel appears.
REQ-038 in_valid toggled randomly, out_ready randomly; compare against a reference model of per-channel signed max over 20 frames; no mismatch, err=0.
